// File: rtl/frog_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frog_pkg
// Description : Definitions shared by the log spawner and the log movers:
//               the spawner FSM state type, the LFSR seed and feedback taps,
//               and the log bank size.
// Revision    : 1.0 - initial release
// ============================================================================
package frog_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } spawn_state_t;

    // Feedback is the XOR of bits 7, 5, 4 and 3 of the current value.
    localparam logic [7:0] c_lfsr_seed = 8'hA5;
    localparam logic [7:0] c_lfsr_taps = 8'hB8;

    // Number of logs in one bank; the log mover sizes its storage from it.
    localparam int bank_size = 4;

endpackage
`default_nettype wire

// File: rtl/lfsr8.sv
`default_nettype none
// ============================================================================
// Module      : lfsr8
// Description : 8-bit Fibonacci LFSR. It shifts left every clock and the
//               feedback bit enters at bit 0.
// Ports       : CLK   - clock
//               RESET - synchronous active-high reset, loads the seed
//               q     - current register value
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr8
    import frog_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    output logic [7:0] q
);

    logic [7:0] l_q;
    logic [7:0] l_d;

    always_comb begin
        l_d = {l_q[6:0], ^(l_q & c_lfsr_taps)};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            l_q <= c_lfsr_seed;
        end else begin
            l_q <= l_d;
        end
    end

    assign q = l_q;

endmodule
`default_nettype wire

// File: rtl/log_spawner.sv
`default_nettype none
// ============================================================================
// Module      : log_spawner
// Description : Control stage for NUM_LOGS log movers. It generates a
//               frame-locked movement tick, enables the logs one by one after
//               the game starts, supplies each log's start offsets, and
//               provides a free-running pseudo-random lane value.
// Ports       : CLK, RESET    - clock, synchronous active-high reset
//               startOfFrame  - one-cycle pulse per video frame
//               game_active   - high while play is running
//               level         - speed level 0..3
//               enable        - per-log enable, bit i drives log i
//               timer_done    - one-cycle movement tick shared by all logs
//               random_0_15   - pseudo-random lane index
//               start_offsetX - packed 9-bit X offset for each log
//               start_offsetY - packed 9-bit Y offset for each log
// Revision    : 1.0 - initial release
// ============================================================================
module log_spawner
    import frog_pkg::*;
#(
    parameter int NUM_LOGS      = 4,
    parameter int SPAWN_GAP     = 32,
    parameter int OFFSET_STEP_X = 160
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  startOfFrame,
    input  logic                  game_active,
    input  logic [1:0]            level,
    output logic [NUM_LOGS-1:0]   enable,
    output logic                  timer_done,
    output logic [3:0]            random_0_15,
    output logic [9*NUM_LOGS-1:0] start_offsetX,
    output logic [9*NUM_LOGS-1:0] start_offsetY
);

    localparam int IDX_W = $clog2(NUM_LOGS) + 1;

    spawn_state_t          state_q, state_d;
    logic [NUM_LOGS-1:0]   enable_q, enable_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [5:0]            gap_cnt_q, gap_cnt_d;
    logic [1:0]            frame_cnt_q, frame_cnt_d;
    logic                  timer_done_q, timer_done_d;
    logic [9*NUM_LOGS-1:0] y_q, y_d;

    logic [7:0] w_lfsr;
    logic [1:0] w_period_last;
    logic       w_lfsr_unused;

    lfsr8 u_lfsr (
        .CLK   (CLK),
        .RESET (RESET),
        .q     (w_lfsr)
    );

    // Only the low five LFSR bits are consumed here.
    assign w_lfsr_unused = ^w_lfsr[7:5];

    // Tick period is 4 - level frames, so the last count value is 3 - level.
    assign w_period_last = 2'd3 - level;

    always_comb begin
        state_d      = state_q;
        enable_d     = enable_q;
        idx_d        = idx_q;
        gap_cnt_d    = gap_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        timer_done_d = 1'b0;
        y_d          = y_q;

        if ((state_q == ARM || state_q == RUN) && startOfFrame) begin
            if (frame_cnt_q >= w_period_last) begin
                timer_done_d = 1'b1;
                frame_cnt_d  = '0;
            end else begin
                frame_cnt_d = frame_cnt_q + 2'd1;
            end
        end

        case (state_q)
            IDLE: begin
                enable_d  = '0;
                idx_d     = '0;
                gap_cnt_d = '0;
                if (game_active) begin
                    state_d     = ARM;
                    enable_d[0] = 1'b1;
                    y_d[8:0]    = {4'b0, w_lfsr[4:0]};
                    idx_d       = IDX_W'(1);
                end
            end

            ARM: begin
                // Abort wins over an activation due in the same cycle.
                if (!game_active) begin
                    state_d  = FLUSH;
                    enable_d = '0;
                end else if (startOfFrame) begin
                    if (gap_cnt_q == 6'(SPAWN_GAP - 1)) begin
                        gap_cnt_d = '0;
                        idx_d     = idx_q + IDX_W'(1);
                        for (int i = 1; i < NUM_LOGS; i++) begin
                            if (idx_q == IDX_W'(i)) begin
                                enable_d[i]     = 1'b1;
                                y_d[9*i +: 9]   = {4'b0, w_lfsr[4:0]};
                            end
                        end
                        if (idx_q == IDX_W'(NUM_LOGS - 1)) begin
                            state_d = RUN;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q + 6'd1;
                    end
                end
            end

            RUN: begin
                if (!game_active) begin
                    state_d  = FLUSH;
                    enable_d = '0;
                end
            end

            FLUSH: begin
                enable_d = '0;
                if (startOfFrame) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d  = IDLE;
                enable_d = '0;
            end
        endcase

        // The frame counter and the tick stay quiet whenever play is not running,
        // including the edge that enters FLUSH.
        if (state_d == IDLE || state_d == FLUSH) begin
            frame_cnt_d  = '0;
            timer_done_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            enable_q     <= '0;
            idx_q        <= '0;
            gap_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            timer_done_q <= 1'b0;
            y_q          <= '0;
        end else begin
            state_q      <= state_d;
            enable_q     <= enable_d;
            idx_q        <= idx_d;
            gap_cnt_q    <= gap_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            timer_done_q <= timer_done_d;
            y_q          <= y_d;
        end
    end

    generate
        for (genvar i = 0; i < NUM_LOGS; i++) begin : g_xoff
            assign start_offsetX[9*i +: 9] = 9'(i * OFFSET_STEP_X);
        end
    endgenerate

    assign enable        = enable_q;
    assign timer_done    = timer_done_q;
    assign random_0_15   = w_lfsr[3:0];
    assign start_offsetY = y_q;

endmodule
`default_nettype wire

// File: tb/tb_log_spawner.sv
`default_nettype none
// ============================================================================
// Module      : tb_log_spawner
// Description : Self-checking bench for log_spawner. A frame-level reference
//               model pushes the expected outputs for every clock edge into a
//               queue; a monitor on the falling edge pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_log_spawner;

    localparam int N     = 4;
    localparam int GAP   = 2;
    localparam int STEPX = 160;
    localparam int LFSR_LEN = 8192;

    logic           CLK = 1'b0;
    logic           RESET = 1'b1;
    logic           startOfFrame = 1'b0;
    logic           game_active = 1'b0;
    logic [1:0]     level = 2'd0;
    logic [N-1:0]   enable;
    logic           timer_done;
    logic [3:0]     random_0_15;
    logic [9*N-1:0] start_offsetX;
    logic [9*N-1:0] start_offsetY;

    log_spawner #(
        .NUM_LOGS      (N),
        .SPAWN_GAP     (GAP),
        .OFFSET_STEP_X (STEPX)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .startOfFrame  (startOfFrame),
        .game_active   (game_active),
        .level         (level),
        .enable        (enable),
        .timer_done    (timer_done),
        .random_0_15   (random_0_15),
        .start_offsetX (start_offsetX),
        .start_offsetY (start_offsetY)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [N-1:0]   en;
        logic           td;
        logic [3:0]     rnd;
        logic [9*N-1:0] y;
    } exp_t;

    exp_t           sb_q[$];
    logic [7:0]     lfsr_seq [0:LFSR_LEN-1];
    logic [9*N-1:0] x_exp;
    int             checks = 0;
    int             errors = 0;

    // Reference model: phase 0 = waiting for a game, 1 = playing, 2 = draining
    // to the next frame after an abort.
    int             m_phase = 0;
    int             m_frames = 0;
    int             m_since_tick = 0;
    int             m_count = 0;
    int             m_cyc = 0;
    logic [N-1:0]   m_en = '0;
    logic [9*N-1:0] m_y = '0;
    logic           m_td = 1'b0;
    logic           prev_td = 1'b0;

    initial begin
        logic [7:0] l;
        lfsr_seq[0] = 8'hA5;
        for (int i = 1; i < LFSR_LEN; i++) begin
            l = lfsr_seq[i-1];
            lfsr_seq[i] = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
        x_exp = '0;
        for (int k = 0; k < N; k++) begin
            x_exp[9*k +: 9] = 9'(k * STEPX);
        end
    end

    always @(posedge CLK) begin
        logic [7:0] l_pre;
        logic [7:0] l_post;
        exp_t       e;
        int         n;
        l_pre = lfsr_seq[m_cyc];
        m_td  = 1'b0;
        if (RESET) begin
            m_phase = 0; m_cyc = 0; m_en = '0; m_y = '0;
            m_count = 0; m_frames = 0; m_since_tick = 0;
        end else begin
            if (m_cyc < LFSR_LEN - 1) m_cyc++;
            case (m_phase)
                0: if (game_active) begin
                    m_phase = 1; m_frames = 0; m_since_tick = 0;
                    m_count = 1; m_en = '0; m_en[0] = 1'b1;
                    m_y[8:0] = {4'b0, l_pre[4:0]};
                end
                1: if (!game_active) begin
                    m_phase = 2; m_en = '0; m_count = 0;
                end else if (startOfFrame) begin
                    m_since_tick++;
                    if (m_since_tick >= 4 - int'(level)) begin
                        m_td = 1'b1;
                        m_since_tick = 0;
                    end
                    m_frames++;
                    n = 1 + m_frames / GAP;
                    if (n > N) n = N;
                    if (n > m_count) begin
                        m_en[n-1] = 1'b1;
                        m_y[9*(n-1) +: 9] = {4'b0, l_pre[4:0]};
                        m_count = n;
                    end
                end
                default: if (startOfFrame) m_phase = 0;
            endcase
        end
        l_post = lfsr_seq[m_cyc];
        e.en  = m_en;
        e.td  = m_td;
        e.rnd = l_post[3:0];
        e.y   = m_y;
        sb_q.push_back(e);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("enable",        64'(enable),        64'(e.en));
            chk("timer_done",    64'(timer_done),    64'(e.td));
            chk("random_0_15",   64'(random_0_15),   64'(e.rnd));
            chk("start_offsetY", 64'(start_offsetY), 64'(e.y));
            chk("start_offsetX", 64'(start_offsetX), 64'(x_exp));
            if (timer_done === 1'b1) begin
                chk("timer_done_single_cycle", 64'(prev_td), 64'd0);
            end
        end
        prev_td = timer_done;
    end

    task automatic cyc(input bit sof);
        startOfFrame = sof;
        @(posedge CLK);
        #1;
    endtask

    task automatic frames(input int n, input int len);
        for (int f = 0; f < n; f++) begin
            cyc(1'b1);
            for (int c = 1; c < len; c++) cyc(1'b0);
        end
    endtask

    initial begin
        int len;
        #1;
        // Reset for two cycles, then watch the LFSR start-up sequence.
        cyc(1'b0); cyc(1'b0);
        RESET = 1'b0;
        cyc(1'b0); cyc(1'b0); cyc(1'b0);

        // Fastest speed: a tick every frame while the logs stagger in.
        level = 2'd3; game_active = 1'b1;
        frames(10, 4);

        // Slowest speed: a tick every fourth frame.
        level = 2'd0;
        frames(12, 4);

        // End the game and drain back to idle.
        game_active = 1'b0;
        frames(2, 4);

        // Abort while two logs are enabled.
        game_active = 1'b1;
        cyc(1'b0);
        frames(3, 4);
        game_active = 1'b0;
        cyc(1'b0); cyc(1'b0);
        frames(2, 4);

        // Reset in RUN on a frame pulse.
        game_active = 1'b1; level = 2'd2;
        frames(9, 4);
        RESET = 1'b1;
        cyc(1'b1);
        RESET = 1'b0; game_active = 1'b0;
        frames(2, 4);

        // Randomized play.
        game_active = 1'b1;
        for (int f = 0; f < 400; f++) begin
            RESET = ($urandom_range(0, 149) == 0);
            cyc(1'b1);
            RESET = 1'b0;
            len = int'($urandom_range(1, 5));
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 19) == 0) game_active = ~game_active;
                if ($urandom_range(0, 9) == 0) level = 2'($urandom);
                cyc(1'b0);
            end
        end

        @(negedge CLK);
        #1;
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
